// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Segment patterns are {a,b,c,d,e,f,g} in active-low form (0 = lit).
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // A single-digit display still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational BCD/hex to 7-segment decoder, active-low output.
// Codes 10..15 show A..F when hex is enabled, otherwise a dash.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Pattern lookup with blanking override.
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (code_i)
                4'h0:    seg_o = SEG_0;
                4'h1:    seg_o = SEG_1;
                4'h2:    seg_o = SEG_2;
                4'h3:    seg_o = SEG_3;
                4'h4:    seg_o = SEG_4;
                4'h5:    seg_o = SEG_5;
                4'h6:    seg_o = SEG_6;
                4'h7:    seg_o = SEG_7;
                4'h8:    seg_o = SEG_8;
                4'h9:    seg_o = SEG_9;
                4'hA:    seg_o = hex_en_i ? SEG_A : SEG_DASH;
                4'hB:    seg_o = hex_en_i ? SEG_B : SEG_DASH;
                4'hC:    seg_o = hex_en_i ? SEG_C : SEG_DASH;
                4'hD:    seg_o = hex_en_i ? SEG_D : SEG_DASH;
                4'hE:    seg_o = hex_en_i ? SEG_E : SEG_DASH;
                4'hF:    seg_o = hex_en_i ? SEG_F : SEG_DASH;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: per-frame snapshot, one digit per
// slot, anode guard at slot start, registered pin outputs.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int   NUM_DIGITS     = 4,
    parameter int   SCAN_DIV       = 100000,
    parameter int   GUARD          = 16,
    parameter bit   SEG_ACTIVE_LOW = 1'b1,
    parameter bit   AN_ACTIVE_LOW  = 1'b1,
    localparam int  IDX_W          = idx_width(NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic                    hex_en_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]        digit_idx_o,
    output logic                    frame_start_o
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d, didx_q;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, frm_digits_s;
    logic [NUM_DIGITS-1:0]   snap_dp_q, frm_dp_s;
    logic                    snap_hex_q, snap_blz_q, frm_hex_s, frm_blz_s;
    logic                    take_snap_s, frame_q;
    logic [3:0]              cur_code_s;
    logic                    cur_dp_s, nonzero_s, blank_s;
    logic [NUM_DIGITS-1:0]   onehot_s, an_on_s, an_d, an_q;
    logic [6:0]              seg_raw_s, seg_on_s, seg_d, seg_q;
    logic                    dp_d, dp_q;

    // Frame starts whenever an enabled cycle sits at slot 0, count 0; the
    // decode path sees the incoming data that same cycle so slot 0 is fresh.
    assign take_snap_s  = enable_i && (presc_q == {PRE_W{1'b0}}) && (idx_q == {IDX_W{1'b0}});
    assign frm_digits_s = take_snap_s ? digits_i   : snap_digits_q;
    assign frm_dp_s     = take_snap_s ? dp_in_i    : snap_dp_q;
    assign frm_hex_s    = take_snap_s ? hex_en_i   : snap_hex_q;
    assign frm_blz_s    = take_snap_s ? blank_lz_i : snap_blz_q;

    // Prescaler and digit index advance.
    always_comb begin
        presc_d = {PRE_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        if (!enable_i) begin
            presc_d = {PRE_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
        end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = {PRE_W{1'b0}};
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PRE_W'(1);
            idx_d   = idx_q;
        end
    end

    // Select the slot digit and look for a non-zero digit at or above it.
    always_comb begin
        cur_code_s = 4'h0;
        cur_dp_s   = 1'b0;
        nonzero_s  = 1'b0;
        onehot_s   = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (IDX_W'(i) == idx_q);
            cur_code_s  = cur_code_s | (onehot_s[i] ? frm_digits_s[4*i +: 4] : 4'h0);
            cur_dp_s    = cur_dp_s | (onehot_s[i] & frm_dp_s[i]);
            nonzero_s   = nonzero_s | ((i >= int'(idx_q)) && (frm_digits_s[4*i +: 4] != 4'h0));
        end
    end

    assign blank_s = frm_blz_s && (idx_q != {IDX_W{1'b0}}) && !nonzero_s;

    seg_hex_decoder u_dec (
        .code_i   (cur_code_s),
        .hex_en_i (frm_hex_s),
        .blank_i  (blank_s),
        .seg_o    (seg_raw_s)
    );

    assign seg_on_s = enable_i ? ~seg_raw_s : 7'h00;
    assign an_on_s  = (enable_i && (int'(presc_q) >= GUARD)) ? onehot_s : {NUM_DIGITS{1'b0}};
    assign seg_d    = SEG_ACTIVE_LOW ? ~seg_on_s : seg_on_s;
    assign dp_d     = SEG_ACTIVE_LOW ? ~(cur_dp_s & enable_i) : (cur_dp_s & enable_i);
    assign an_d     = AN_ACTIVE_LOW ? ~an_on_s : an_on_s;

    // State, snapshot and pin registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q       <= {PRE_W{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            didx_q        <= {IDX_W{1'b0}};
            snap_digits_q <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_q     <= {NUM_DIGITS{1'b0}};
            snap_hex_q    <= 1'b0;
            snap_blz_q    <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            didx_q  <= enable_i ? idx_q : {IDX_W{1'b0}};
            frame_q <= take_snap_s;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            if (take_snap_s) begin
                snap_digits_q <= digits_i;
                snap_dp_q     <= dp_in_i;
                snap_hex_q    <= hex_en_i;
                snap_blz_q    <= blank_lz_i;
            end else begin
                snap_digits_q <= snap_digits_q;
                snap_dp_q     <= snap_dp_q;
                snap_hex_q    <= snap_hex_q;
                snap_blz_q    <= snap_blz_q;
            end
        end
    end

    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign an_o          = an_q;
    assign digit_idx_o   = didx_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, 8 cycles/slot, guard 2.
module tb_seven_seg_scan_driver;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp_in;
        logic            hex_en;
        logic            blz;
        logic [3:0][6:0] segs;    // expected active-low seg per slot
        logic [3:0]      dp_exp;  // expected active-low dp per slot
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        hex_en = 1'b1;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[8];
    vec_t v1234, v5678, v9087;

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .digits_i(digits),
        .dp_in_i(dp_in), .hex_en_i(hex_en), .blank_lz_i(blank_lz),
        .seg_o(seg), .dp_o(dp), .an_o(an), .digit_idx_o(digit_idx),
        .frame_start_o(frame_start)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dpi,
                                input logic hx, input logic bz,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [3:0] dpe);
        vec_t v;
        v.digits = d; v.dp_in = dpi; v.hex_en = hx; v.blz = bz;
        v.segs = {s3, s2, s1, s0}; v.dp_exp = dpe;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        digits = v.digits; dp_in = v.dp_in; hex_en = v.hex_en; blank_lz = v.blz;
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_an"}, 0, {4'h0, an}, 8'h0F);
        chk({nm, "_seg"}, 0, {1'b0, seg}, 8'h7F);
        chk({nm, "_dp"}, 0, {7'h00, dp}, 8'h01);
        chk({nm, "_idx"}, 0, {6'h00, digit_idx}, 8'h00);
        chk({nm, "_fs"}, 0, {7'h00, frame_start}, 8'h00);
    endtask

    // Check ncyc output cycles of a frame; optionally change digits after cycle chg_k.
    task automatic run_frame(input vec_t v, input int ncyc, input int chg_k, input logic [15:0] chg_d);
        int s, p;
        logic [3:0] ea;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            s = (k - 1) / 8;
            p = (k - 1) % 8;
            ea = 4'b0001 << s;
            ea = (p < 2) ? 4'hF : ~ea;
            chk("an", k, {4'h0, an}, {4'h0, ea});
            chk("seg", k, {1'b0, seg}, {1'b0, v.segs[s]});
            chk("dp", k, {7'h00, dp}, {7'h00, v.dp_exp[s]});
            chk("idx", k, {6'h00, digit_idx}, 8'(s));
            chk("fs", k, {7'h00, frame_start}, {7'h00, (k == 1)});
            if (k == chg_k) digits = chg_d;
        end
    endtask

    initial begin
        v1234 = mk(16'h1234, 4'h0, 1'b1, 1'b0, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 4'hF);
        v5678 = mk(16'h5678, 4'h0, 1'b1, 1'b0, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 4'hF);
        v9087 = mk(16'h9087, 4'b0101, 1'b0, 1'b1, 7'b0001111, 7'b0000000, 7'b0000001, 7'b0000100, 4'b1010);
        tbl[0] = v1234;
        tbl[1] = mk(16'hABCF, 4'h0, 1'b1, 1'b0, 7'b0111000, 7'b0110001, 7'b1100000, 7'b0001000, 4'hF);
        tbl[2] = mk(16'hABCF, 4'h0, 1'b0, 1'b0, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'hF);
        tbl[3] = mk(16'h0050, 4'b1000, 1'b1, 1'b1, 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111, 4'b0111);
        tbl[4] = mk(16'h0000, 4'h0, 1'b1, 1'b1, 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'hF);
        tbl[5] = v9087;
        tbl[6] = mk(16'h0100, 4'h0, 1'b0, 1'b1, 7'b0000001, 7'b0000001, 7'b1001111, 7'b1111111, 4'hF);
        tbl[7] = mk(16'hED00, 4'b0010, 1'b1, 1'b1, 7'b0000001, 7'b0000001, 7'b1000010, 7'b0110000, 4'b1101);

        apply(tbl[0]);
        #12;
        chk_dark("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            run_frame(tbl[i], 32, 0, 16'h0000);
        end

        // Mid-frame input change must wait for the next frame.
        apply(v1234);
        run_frame(v1234, 32, 18, 16'h5678);
        run_frame(v5678, 32, 0, 16'h0000);

        // Drop enable in slot 2, then re-raise.
        apply(v1234);
        run_frame(v1234, 19, 0, 16'h0000);
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_dark("disabled");
        end
        enable = 1'b1;
        run_frame(v1234, 32, 0, 16'h0000);

        // Async reset pulse between edges while an anode is lit.
        run_frame(v1234, 12, 0, 16'h0000);
        #2;
        reset = 1'b1;
        apply(v9087);
        #1;
        chk_dark("async_rst");
        #1;
        reset = 1'b0;
        run_frame(v9087, 32, 0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display, generalising the single-digit BCD decoder.
- Snapshots a packed BCD/hex digit vector once per frame and scans one digit per slot.
- Performs decode with optional hex, leading-zero blanking and decimal points.
- Applies a ghosting guard between digits.
- Sits between the clock/counter core and the board display pins.

Parameters:
NUM_DIGITS, 4, digits scanned (1..8)
SCAN_DIV, 100000, clk cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at start of each slot with all anodes off (0 allowed)
SEG_ACTIVE_LOW, 1, 1 = segment/dp lit when 0
AN_ACTIVE_LOW, 1, 1 = anode enabled when 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scanning; 0 = display dark, counters held
digits  in  4*NUM_DIGITS  digit i at [4i+3:4i]; digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
hex_en  in  1  1 = codes 10..15 show A..F; 0 = show dash
blank_lz  in  1  1 = suppress leading zeros
seg  out  7  {a,b,c,d,e,f,g}, seg[6]=a
dp  out  1  decimal point
an  out  NUM_DIGITS  anode enables, one-hot when active
digit_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently in slot
frame_start  out  1  one-cycle pulse when snapshot taken

Behaviour:
- Reset (async, immediate): prescaler=0, digit_idx=0, snapshot regs=0, frame_start=0, seg/dp/an at inactive levels (active-low: seg=7'b1111111, dp=1, an=all 1).
- Prescaler counts 0..SCAN_DIV-1 while enable=1.
  - At SCAN_DIV-1 it wraps to 0 and digit_idx advances; N-1 wraps to 0.
- Snapshot:
  - When digit_idx wraps N-1->0, and on the first enabled cycle after reset or after enable rises, digits/dp_in/hex_en/blank_lz are copied into internal regs.
  - frame_start pulses in that same cycle.
  - Input changes mid-frame never appear until the next frame (no tearing).
- Outputs are registered: seg/dp/an reflect prescaler/digit_idx of the previous cycle (1-cycle latency).
- Within a slot, an is inactive for output cycles 1..GUARD, then one-hot for digit digit_idx for the remaining SCAN_DIV-GUARD cycles.
  - seg/dp are updated to the new digit's pattern at slot start, so they are stable before the anode turns on.
- Decode, with polarity applied by SEG_ACTIVE_LOW (values below are active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - hex_en=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - hex_en=0: codes 10..15 = dash 1111110.
- Leading-zero blank: digit i (i>0) is blanked (seg all off) when blank_lz=1 and every snapshot digit j>=i equals 0.
  - Digit 0 is never blanked.
  - dp is still driven for a blanked digit if its dp_in bit is set.
- enable=0:
  - Next cycle: an inactive, seg/dp inactive, prescaler=0, digit_idx=0.
  - On enable rising: snapshot plus frame_start in the first enabled cycle, then a normal slot 0 (including guard).
- NUM_DIGITS=1: digit_idx stays 0; a snapshot is taken every slot.
- Reset asserted mid-slot forces the reset values immediately; after release the scan restarts at digit 0 with a fresh snapshot.

Decomposition:
- Package seven_seg_pkg:
  - active-low segment constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK
  - localparam helper for the digit_idx width
- Sub-module seg_hex_decoder: combinational, inputs code[3:0], hex_en, blank; output seg[6:0] active-low.
  - The driver applies the polarity inversion.

Test Plan:
Common config unless stated: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, active-low; enable=1.
- Reset/scan: digits=16'h1234, dp_in=0, blank_lz=0.
  - After reset release, slot 0: an=1111 for 2 cycles, then an=1110 with seg=1001100 ("4") for 6 cycles.
  - Then digit 1: "3"=0000110 on an=1101, etc.
  - frame_start every 32 cycles.
- Snapshot: change digits 16'h1234 -> 16'h5678 during digit 2's slot.
  - Digits 2 and 3 still show "2" and "1".
  - The next frame shows 8,7,6,5.
- Hex vs dash: digits=16'hABCF.
  - hex_en=1: seg sequence F,C,b,A (0111000, 0110001, 1100000, 0001000).
  - hex_en=0: all four slots show 1111110.
- Leading zeros: digits=16'h0050, blank_lz=1, dp_in=4'b1000.
  - Digit 0 = "0", digit 1 = "5", digit 2 seg=1111111.
  - Digit 3 seg=1111111 with dp=0.
  - digits=16'h0000: only digit 0 shows "0".
- Enable/async reset:
  - Drop enable mid-slot 2: next cycle an=1111, seg=1111111.
  - Re-raise: frame_start plus slot 0 with guard.
  - Pulse reset between clock edges: outputs go inactive without waiting for a clk edge.
